// File: rtl/trap_controller.sv
// Trap sequencer: takes exceptions, user interrupts and URET through the CSR file's
// single read port, then issues the ucause/uepc/ustatus writes and the PC redirect.
module trap_controller #(
  parameter logic [6:0] USTATUS_ADDR = 7'd0,
  parameter logic [6:0] UIE_ADDR     = 7'd4,
  parameter logic [6:0] UTVEC_ADDR   = 7'd5,
  parameter logic [6:0] UEPC_ADDR    = 7'd65
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iPC,
  input  logic        iExcValid,
  input  logic [4:0]  iExcCode,
  input  logic        iExtIrq,
  input  logic        iTimerIrq,
  input  logic        iURET,
  output logic [6:0]  oCSReadRegister,
  input  logic [31:0] iCSReadData,
  output logic        oCSRegWrite,
  output logic [6:0]  oCSWriteRegister,
  output logic [31:0] oCSWriteData,
  output logic        oUCAUSEWrite,
  output logic        oUEPCWrite,
  output logic [31:0] oUCAUSEData,
  output logic [31:0] oUEPCData,
  output logic        oBusy,
  output logic        oPCRedirect,
  output logic [31:0] oNewPC
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_IRQCHK    = 3'd1;
  localparam logic [2:0] S_TVEC      = 3'd2;
  localparam logic [2:0] S_COMMIT    = 3'd3;
  localparam logic [2:0] S_RET       = 3'd4;
  localparam logic [2:0] S_RETCOMMIT = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] tvec_base_s;

  // Trap entry: UPIE takes the old UIE, UIE is cleared.
  function automatic logic [31:0] trap_status(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[4] = s[0];
    r[0] = 1'b0;
    return r;
  endfunction

  // Trap return: UIE restored from UPIE, UPIE set.
  function automatic logic [31:0] ret_status(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[0] = s[4];
    r[4] = 1'b1;
    return r;
  endfunction

  assign tvec_base_s = {iCSReadData[31:2], 2'b00};

  // Next-state and latch updates for the trap sequence.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        status_d = iCSReadData;
        if (iExcValid) begin
          cause_d = {27'd0, iExcCode};
          epc_d   = iPC;
          state_d = S_TVEC;
        end else if (iURET) begin
          state_d = S_RET;
        end else if ((iExtIrq | iTimerIrq) & iCSReadData[0]) begin
          epc_d   = iPC;
          state_d = S_IRQCHK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IRQCHK: begin
        if (iExtIrq & iCSReadData[8]) begin
          cause_d = 32'h8000_0008;
          state_d = S_TVEC;
        end else if (iTimerIrq & iCSReadData[4]) begin
          cause_d = 32'h8000_0004;
          state_d = S_TVEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TVEC: begin
        // Vectored mode only applies to interrupts; exceptions always go to base.
        if ((iCSReadData[1:0] == 2'b01) && cause_q[31]) begin
          target_d = tvec_base_s + {26'd0, cause_q[3:0], 2'b00};
        end else begin
          target_d = tvec_base_s;
        end
        state_d = S_COMMIT;
      end
      S_COMMIT:    state_d = S_IDLE;
      S_RET: begin
        epc_d   = iCSReadData;
        state_d = S_RETCOMMIT;
      end
      S_RETCOMMIT: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      status_q <= 32'd0;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      target_q <= target_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    oCSReadRegister = USTATUS_ADDR;
    oCSRegWrite     = 1'b0;
    oCSWriteData    = 32'd0;
    oUCAUSEWrite    = 1'b0;
    oUEPCWrite      = 1'b0;
    oPCRedirect     = 1'b0;
    oNewPC          = 32'd0;
    case (state_q)
      S_IDLE:   oCSReadRegister = USTATUS_ADDR;
      S_IRQCHK: oCSReadRegister = UIE_ADDR;
      S_TVEC:   oCSReadRegister = UTVEC_ADDR;
      S_COMMIT: begin
        oCSRegWrite  = 1'b1;
        oUCAUSEWrite = 1'b1;
        oUEPCWrite   = 1'b1;
        oCSWriteData = trap_status(status_q);
        oPCRedirect  = 1'b1;
        oNewPC       = target_q;
      end
      S_RET:    oCSReadRegister = UEPC_ADDR;
      S_RETCOMMIT: begin
        oCSRegWrite  = 1'b1;
        oCSWriteData = ret_status(status_q);
        oPCRedirect  = 1'b1;
        oNewPC       = epc_q;
      end
      default:  oCSReadRegister = USTATUS_ADDR;
    endcase
  end

  assign oCSWriteRegister = USTATUS_ADDR;
  assign oUCAUSEData      = cause_q;
  assign oUEPCData        = epc_q;
  assign oBusy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: stimulus pushes expected redirects,
// a negedge monitor pops and compares them and watches strobes/busy.
module tb_trap_controller;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iPC;
  logic        iExcValid;
  logic [4:0]  iExcCode;
  logic        iExtIrq;
  logic        iTimerIrq;
  logic        iURET;
  logic [6:0]  oCSReadRegister;
  logic [31:0] iCSReadData;
  logic        oCSRegWrite;
  logic [6:0]  oCSWriteRegister;
  logic [31:0] oCSWriteData;
  logic        oUCAUSEWrite;
  logic        oUEPCWrite;
  logic [31:0] oUCAUSEData;
  logic [31:0] oUEPCData;
  logic        oBusy;
  logic        oPCRedirect;
  logic [31:0] oNewPC;

  trap_controller dut (
    .iCLK(iCLK), .iRST(iRST), .iPC(iPC), .iExcValid(iExcValid), .iExcCode(iExcCode),
    .iExtIrq(iExtIrq), .iTimerIrq(iTimerIrq), .iURET(iURET),
    .oCSReadRegister(oCSReadRegister), .iCSReadData(iCSReadData),
    .oCSRegWrite(oCSRegWrite), .oCSWriteRegister(oCSWriteRegister), .oCSWriteData(oCSWriteData),
    .oUCAUSEWrite(oUCAUSEWrite), .oUEPCWrite(oUEPCWrite),
    .oUCAUSEData(oUCAUSEData), .oUEPCData(oUEPCData),
    .oBusy(oBusy), .oPCRedirect(oPCRedirect), .oNewPC(oNewPC)
  );

  initial forever #5 iCLK = ~iCLK;

  typedef struct {
    int unsigned cyc;
    bit          is_ret;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] wdata;
    logic [31:0] newpc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          errs = 0;
  int          checks = 0;
  bit          chk_rst;
  bit          exp_busy_en;
  bit          exp_busy;

  logic [31:0] ustatus, uie, utvec, uepc;

  // CSR file model: combinational read port
  always_comb begin
    case (oCSReadRegister)
      7'd0:    iCSReadData = ustatus;
      7'd4:    iCSReadData = uie;
      7'd5:    iCSReadData = utvec;
      7'd65:   iCSReadData = uepc;
      default: iCSReadData = 32'd0;
    endcase
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge iCLK) begin
    if (chk_rst) begin
      chk("rst_busy", {31'd0, oBusy}, 32'd0);
      chk("rst_redirect", {31'd0, oPCRedirect}, 32'd0);
      chk("rst_strobes", {29'd0, oCSRegWrite, oUCAUSEWrite, oUEPCWrite}, 32'd0);
      chk("rst_newpc", oNewPC, 32'd0);
      chk("rst_ucause", oUCAUSEData, 32'd0);
      chk("rst_uepc", oUEPCData, 32'd0);
      chk("rst_wdata", oCSWriteData, 32'd0);
      chk("rst_rdreg", {25'd0, oCSReadRegister}, 32'd0);
    end
    if (!iRST) begin
      if (oPCRedirect) begin
        if (sb.size() == 0) begin
          chk("unexpected_redirect_newpc", oNewPC, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("latency_cycle", cyc, mon_e.cyc);
          chk("newpc", oNewPC, mon_e.newpc);
          chk("ustatus_wdata", oCSWriteData, mon_e.wdata);
          chk("ustatus_wreg", {25'd0, oCSWriteRegister}, 32'd0);
          chk("ustatus_we", {31'd0, oCSRegWrite}, 32'd1);
          chk("ucause_we", {31'd0, oUCAUSEWrite}, {31'd0, ~mon_e.is_ret});
          chk("uepc_we", {31'd0, oUEPCWrite}, {31'd0, ~mon_e.is_ret});
          chk("uepc_data", oUEPCData, mon_e.epc);
          if (!mon_e.is_ret) chk("ucause_data", oUCAUSEData, mon_e.cause);
        end
      end else begin
        chk("quiet_strobes", {29'd0, oCSRegWrite, oUCAUSEWrite, oUEPCWrite}, 32'd0);
        if (sb.size() != 0 && cyc > sb[0].cyc) begin
          mon_e = sb.pop_front();
          chk("redirect_timeout_cycle", cyc, mon_e.cyc);
        end
      end
      if (exp_busy_en) chk("busy", {31'd0, oBusy}, {31'd0, exp_busy});
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push(input int unsigned lat, input bit r, input logic [31:0] cause,
                      input logic [31:0] epc, input logic [31:0] wdata, input logic [31:0] newpc);
    exp_t e;
    e.cyc = cyc + lat; e.is_ret = r; e.cause = cause;
    e.epc = epc; e.wdata = wdata; e.newpc = newpc;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    tick();
    tick();
  endtask

  initial begin
    iRST = 1'b1; iPC = 32'd0; iExcValid = 1'b0; iExcCode = 5'd0;
    iExtIrq = 1'b0; iTimerIrq = 1'b0; iURET = 1'b0;
    ustatus = 32'd0; uie = 32'd0; utvec = 32'd0; uepc = 32'd0;
    chk_rst = 1'b1; exp_busy_en = 1'b0; exp_busy = 1'b0;
    tick(); tick();
    iRST = 1'b0;
    tick();
    chk_rst = 1'b0;

    // Illegal-instruction exception, direct mode
    ustatus = 32'h1; utvec = 32'h0040_0100; iPC = 32'h0040_0010;
    iExcCode = 5'd2; iExcValid = 1'b1;
    push(2, 1'b0, 32'h2, 32'h0040_0010, 32'h10, 32'h0040_0100);
    tick(); iExcValid = 1'b0;
    drain();

    // External interrupt, vectored
    ustatus = 32'h1; uie = 32'h100; utvec = 32'h0040_0101; iPC = 32'h0040_0200;
    iExtIrq = 1'b1;
    push(3, 1'b0, 32'h8000_0008, 32'h0040_0200, 32'h10, 32'h0040_0120);
    tick(); tick(); iExtIrq = 1'b0;
    drain();

    // Timer interrupt, vectored
    ustatus = 32'h1; uie = 32'h10; utvec = 32'h0040_0001; iPC = 32'h0040_0300;
    iTimerIrq = 1'b1;
    push(3, 1'b0, 32'h8000_0004, 32'h0040_0300, 32'h10, 32'h0040_0010);
    tick(); tick(); iTimerIrq = 1'b0;
    drain();

    // Interrupts globally disabled: never busy
    ustatus = 32'h0; uie = 32'h110; iTimerIrq = 1'b1;
    exp_busy_en = 1'b1; exp_busy = 1'b0;
    tick(); tick(); tick();
    iTimerIrq = 1'b0;
    tick();
    exp_busy_en = 1'b0;

    // Enabled globally but masked in uie: IRQCHK then back to IDLE
    ustatus = 32'h1; uie = 32'h0; iTimerIrq = 1'b1;
    tick();
    exp_busy_en = 1'b1; exp_busy = 1'b1;
    tick();
    exp_busy = 1'b0; iTimerIrq = 1'b0;
    tick();
    exp_busy_en = 1'b0;
    tick();

    // Request dropped before IRQCHK aborts
    ustatus = 32'h1; uie = 32'h100; iExtIrq = 1'b1;
    tick();
    iExtIrq = 1'b0; exp_busy_en = 1'b1; exp_busy = 1'b1;
    tick();
    exp_busy = 1'b0;
    tick(); tick();
    exp_busy_en = 1'b0;

    // Exception wins over URET and interrupt in the same cycle
    ustatus = 32'h1; uie = 32'h100; utvec = 32'h0040_0101; iPC = 32'h0040_0400;
    iExcCode = 5'd8; iExcValid = 1'b1; iURET = 1'b1; iExtIrq = 1'b1;
    push(2, 1'b0, 32'h8, 32'h0040_0400, 32'h10, 32'h0040_0100);
    tick(); iExcValid = 1'b0; iURET = 1'b0; iExtIrq = 1'b0;
    drain();

    // URET
    ustatus = 32'h10; uepc = 32'h0040_0044; iURET = 1'b1;
    push(2, 1'b1, 32'h0, 32'h0040_0044, 32'h11, 32'h0040_0044);
    tick(); iURET = 1'b0;
    drain();

    // Reset in TVEC: async return to reset values, no strobes after
    ustatus = 32'h0; utvec = 32'h0040_0100; iPC = 32'h0040_0500;
    iExcCode = 5'd2; iExcValid = 1'b1;
    tick(); iExcValid = 1'b0;
    iRST = 1'b1; chk_rst = 1'b1;
    tick();
    iRST = 1'b0;
    tick();
    chk_rst = 1'b0; exp_busy_en = 1'b1; exp_busy = 1'b0;
    tick(); tick(); tick();
    exp_busy_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Multicycle trap sequencer that drives the CSR register file from the control side. It detects synchronous exceptions, user-mode interrupts and URET. It then reads ustatus/uie/utvec/uepc through the CSR file's single read port and issues the ucause, uepc and ustatus writes. Finally it redirects the PC. It sits between the core datapath/control unit and the CSR file, and stalls the core while a sequence is in flight.

## Interface
Parameters:
- USTATUS_ADDR, 7'd0, CSR index of ustatus
- UIE_ADDR, 7'd4, CSR index of uie
- UTVEC_ADDR, 7'd5, CSR index of utvec
- UEPC_ADDR, 7'd65, CSR index of uepc (read side)

Ports:
- iCLK  in  1  clock; all state updates on posedge
- iRST  in  1  asynchronous, active-high reset
- iPC  in  32  PC of the instruction in the trap stage
- iExcValid  in  1  synchronous exception pulse, sampled in IDLE only
- iExcCode  in  5  exception code (e.g. 2 illegal, 8 ecall)
- iExtIrq, iTimerIrq  in  1 each  level interrupt requests
- iURET  in  1  URET executed, sampled in IDLE only
- oCSReadRegister  out  7  CSR read index
- iCSReadData  in  32  combinational read data from the CSR file
- oCSRegWrite  out  1  ustatus write strobe
- oCSWriteRegister  out  7  always USTATUS_ADDR
- oCSWriteData  out  32  new ustatus value
- oUCAUSEWrite, oUEPCWrite  out  1 each  ucause/uepc write strobes
- oUCAUSEData, oUEPCData  out  32 each  ucause/uepc write data
- oBusy  out  1  high in every state except IDLE; the core holds its PC and stage registers
- oPCRedirect  out  1  one-cycle redirect pulse
- oNewPC  out  32  redirect target, valid while oPCRedirect=1

## Operation
States:
- **IDLE**
  - oCSReadRegister=USTATUS_ADDR; status latched each cycle from iCSReadData.
  - Priority: iExcValid > iURET > interrupt.
  - Exception: cause={1'b0,26'b0,iExcCode}; epc=iPC; go to TVEC.
  - URET: go to RET.
  - Interrupt: (iExtIrq|iTimerIrq) and ustatus[0] (UIE)=1; epc=iPC; go to IRQCHK.
- **IRQCHK**
  - oCSReadRegister=UIE_ADDR.
  - iExtIrq & uie[8]: cause=32'h8000_0008, go to TVEC.
  - Else iTimerIrq & uie[4]: cause=32'h8000_0004, go to TVEC.
  - Else return to IDLE; no writes, no redirect.
- **TVEC**
  - oCSReadRegister=UTVEC_ADDR.
  - base={tvec[31:2],2'b00}.
  - If tvec[1:0]==2'b01 and cause[31]=1: target=base+(cause[3:0]<<2), 32-bit modulo.
  - Otherwise: target=base.
  - Go to COMMIT.
- **COMMIT**
  - oUCAUSEWrite=oUEPCWrite=oCSRegWrite=1.
  - oCSWriteData = status with bit4 (UPIE)=status[0] and bit0 (UIE)=0; all other bits unchanged.
  - oPCRedirect=1, oNewPC=target.
  - Go to IDLE.
- **RET**
  - oCSReadRegister=UEPC_ADDR; epc latched; go to RETCOMMIT.
- **RETCOMMIT**
  - oCSRegWrite=1; oCSWriteData = status with UIE=status[4] and UPIE=1.
  - oPCRedirect=1, oNewPC=epc.
  - Go to IDLE.

Rules:
- All strobes are low outside COMMIT and RETCOMMIT.
- oUCAUSEData and oUEPCData always reflect the latched cause and epc.
- iExcValid, iURET and interrupts arriving while oBusy=1 are ignored. Upstream re-presents them if required.
- Interrupt levels are re-evaluated in IRQCHK. A request dropped between IDLE and IRQCHK aborts to IDLE.

## Timing
- Reset: state=IDLE and all latches cleared.
  - Outputs after reset: oBusy=0, oPCRedirect=0, all write strobes=0, oNewPC=0, oUCAUSEData=0, oUEPCData=0, oCSWriteData=0, oCSReadRegister=USTATUS_ADDR.
- Reset asserted mid-sequence returns to IDLE immediately. No partial CSR write is issued after reset deasserts.
- Redirect latencies, with the triggering event sampled at edge 0:
  - Exception: COMMIT in cycle 2.
  - Accepted interrupt: COMMIT in cycle 3.
  - URET: RETCOMMIT in cycle 2.
- CSR writes land at the posedge ending COMMIT/RETCOMMIT. The first IDLE cycle afterwards reads the updated ustatus.
- oBusy goes high the cycle after acceptance and stays high through COMMIT/RETCOMMIT. During those cycles the core holds its state.

## Test plan
- Reset, then iExcValid=1, iExcCode=2, iPC=0x0040_0010, utvec=0x0040_0100, ustatus=0x1:
  - COMMIT at cycle 2 with ucause=0x2, uepc=0x0040_0010, ustatus write 0x10.
  - oNewPC=0x0040_0100.
- ustatus=0x1, uie=0x100, utvec=0x0040_0101, iExtIrq=1:
  - Redirect at cycle 3 with ucause=0x8000_0008 and oNewPC=0x0040_0120.
- ustatus=0x0, iTimerIrq=1:
  - oBusy stays 0 and no strobes are issued.
  - With ustatus=0x1 and uie=0x0: IRQCHK is entered, then the block returns to IDLE with no writes.
- Same-cycle iExcValid=1 (code 8), iURET=1, iExtIrq=1:
  - The exception sequence runs, ucause=0x8, and URET is ignored.
- ustatus=0x10, uepc=0x0040_0044, iURET=1:
  - RETCOMMIT at cycle 2 writes ustatus=0x11.
  - oNewPC=0x0040_0044; oUEPCWrite and oUCAUSEWrite stay 0.
- Assert iRST during TVEC:
  - No strobes are issued, and all outputs return to their reset values asynchronously.
